histogram_ctrl: RTL and testbench

Frame-level sequencer for the 1024-bin histogram datapath. It gates pixels into the histogram during a frame and signals frame completion. It then performs a destructive sweep readout of every bin onto a ready/valid stream, which leaves the memory zeroed for the next frame. It sits between the sensor pixel front end and the histogram memory, and owns the memory's `rw`, `pixel`, `pixel_valid`, `image_done` and `bin` inputs.

---
 rtl/histogram_ctrl_if.sv | 50 +++++
 rtl/histogram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_histogram_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_ctrl_if.sv
// +------------------------------------------------------------------+
// | histogram_ctrl_if : pixel, histogram-memory and readout bundle   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface histogram_ctrl_if #(
   parameter int BIN_W   = 10,
   parameter int COUNT_W = 24
);
   // front end
   logic               frame_start;
   logic               frame_end;
   logic [BIN_W-1:0]   pix_in;
   logic               pix_in_valid;
   // histogram memory
   logic               hist_rw;
   logic [BIN_W-1:0]   hist_pixel;
   logic               hist_pixel_valid;
   logic               hist_image_done;
   logic [BIN_W-1:0]   hist_bin;
   logic [COUNT_W-1:0] hist_data;
   // readout stream and status
   logic               out_valid;
   logic               out_ready;
   logic [BIN_W-1:0]   out_bin;
   logic [COUNT_W-1:0] out_count;
   logic               out_last;
   logic               busy;
   logic               frame_dropped;
   logic [31:0]        pixel_count;
   logic [15:0]        frame_count;

   modport master (
      input  frame_start, frame_end, pix_in, pix_in_valid, hist_data, out_ready,
      output hist_rw, hist_pixel, hist_pixel_valid, hist_image_done, hist_bin,
             out_valid, out_bin, out_count, out_last, busy, frame_dropped,
             pixel_count, frame_count
   );

   modport slave (
      output frame_start, frame_end, pix_in, pix_in_valid, hist_data, out_ready,
      input  hist_rw, hist_pixel, hist_pixel_valid, hist_image_done, hist_bin,
             out_valid, out_bin, out_count, out_last, busy, frame_dropped,
             pixel_count, frame_count
   );
endinterface

`default_nettype wire

// File: rtl/histogram_ctrl.sv
// +------------------------------------------------------------------+
// | histogram_ctrl : frame sequencer with destructive sweep readout  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module histogram_ctrl #(
   parameter int NUM_BINS = 1024,
   parameter int BIN_W    = 10,
   parameter int COUNT_W  = 24,
   parameter int RD_LAT   = 1
) (
   input wire               clk,
   input wire               rst,
   histogram_ctrl_if.master bus
);
   localparam logic [BIN_W-1:0]    c_last_bin  = BIN_W'(NUM_BINS - 1);
   localparam int                  c_wait_w    = $clog2(RD_LAT + 2);
   localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(RD_LAT);

   typedef enum logic [2:0] {
      S_CLEAR      = 3'd0,
      S_IDLE       = 3'd1,
      S_ACQ        = 3'd2,
      S_DRAIN1     = 3'd3,
      S_DRAIN2     = 3'd4,
      S_RD_ADDR    = 3'd5,
      S_RD_PRESENT = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [BIN_W-1:0]     r_bin;
   logic [c_wait_w-1:0]  r_wait;
   logic [BIN_W-1:0]     r_hist_pixel;
   logic                 r_hist_pixel_valid;
   logic [BIN_W-1:0]     r_out_bin;
   logic [COUNT_W-1:0]   r_out_count;
   logic                 r_frame_dropped;
   logic [31:0]          r_pixel_count;
   logic [15:0]          r_frame_count;

   logic w_last_bin;
   logic w_rd_done;
   logic w_hist_rw;
   logic w_image_done;
   logic w_out_valid;
   logic w_busy;

   assign w_last_bin = (r_bin == c_last_bin);
   assign w_rd_done  = (r_wait == c_wait_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_hist_rw    = 1'b0;
      w_image_done = 1'b0;
      w_out_valid  = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         S_CLEAR: begin
            if (w_last_bin) w_next = S_IDLE;
         end
         S_IDLE: begin
            w_hist_rw = 1'b1;
            w_busy    = 1'b0;
            if (bus.frame_start) w_next = S_ACQ;
         end
         S_ACQ: begin
            w_hist_rw = 1'b1;
            if (bus.frame_end) w_next = S_DRAIN1;
         end
         S_DRAIN1: begin
            w_hist_rw = 1'b1;
            w_next    = S_DRAIN2;
         end
         S_DRAIN2: begin
            w_hist_rw    = 1'b1;
            w_image_done = 1'b1;
            w_next       = S_RD_ADDR;
         end
         S_RD_ADDR: begin
            if (w_rd_done) w_next = S_RD_PRESENT;
         end
         S_RD_PRESENT: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_next = w_last_bin ? S_IDLE : S_RD_ADDR;
         end
         default: begin
            w_next = S_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bin              <= '0;
         r_wait             <= '0;
         r_hist_pixel       <= '0;
         r_hist_pixel_valid <= 1'b0;
         r_out_bin          <= '0;
         r_out_count        <= '0;
         r_frame_dropped    <= 1'b0;
         r_pixel_count      <= '0;
         r_frame_count      <= '0;
      end else begin
         // The pixel from the frame_end cycle still lands during DRAIN1.
         r_hist_pixel       <= bus.pix_in;
         r_hist_pixel_valid <= (r_state == S_ACQ) && bus.pix_in_valid;
         r_frame_dropped    <= bus.frame_start && (r_state != S_IDLE);

         case (r_state)
            S_CLEAR: begin
               r_bin <= w_last_bin ? '0 : r_bin + BIN_W'(1);
            end
            S_IDLE: begin
               if (bus.frame_start) r_pixel_count <= '0;
            end
            S_ACQ: begin
               if (bus.pix_in_valid && (r_pixel_count != '1))
                  r_pixel_count <= r_pixel_count + 32'd1;
            end
            S_DRAIN2: begin
               r_bin  <= '0;
               r_wait <= '0;
            end
            S_RD_ADDR: begin
               // Last wait cycle: hist_data reflects the first read of this bin.
               if (w_rd_done) begin
                  r_out_bin   <= r_bin;
                  r_out_count <= bus.hist_data;
               end else begin
                  r_wait <= r_wait + c_wait_w'(1);
               end
            end
            S_RD_PRESENT: begin
               r_wait <= '0;
               if (bus.out_ready) begin
                  if (w_last_bin) r_frame_count <= r_frame_count + 16'd1;
                  else            r_bin         <= r_bin + BIN_W'(1);
               end
            end
            default: begin
               r_wait <= '0;
            end
         endcase
      end
   end

   assign bus.hist_rw          = w_hist_rw;
   assign bus.hist_pixel       = r_hist_pixel;
   assign bus.hist_pixel_valid = r_hist_pixel_valid;
   assign bus.hist_image_done  = w_image_done;
   assign bus.hist_bin         = r_bin;
   assign bus.out_valid        = w_out_valid;
   assign bus.out_bin          = r_out_bin;
   assign bus.out_count        = r_out_count;
   assign bus.out_last         = w_out_valid && (r_out_bin == c_last_bin);
   assign bus.busy             = w_busy;
   assign bus.frame_dropped    = r_frame_dropped;
   assign bus.pixel_count      = r_pixel_count;
   assign bus.frame_count      = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_histogram_ctrl.sv
// Bench for histogram_ctrl: behavioural histogram memory, scoreboard queue of
// expected readout beats, directed frames with hand-computed bin contents.
`timescale 1ns/1ps
`default_nettype none

module tb_histogram_ctrl;
   localparam int NB = 1024;
   localparam int BW = 10;
   localparam int CW = 24;

   typedef struct packed {
      logic [BW-1:0] bin;
      logic [CW-1:0] cnt;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int beats = 0;
   int drop_seen = 0;

   beat_t         exp_q[$];
   beat_t         mon_e;
   int            exp_hist [NB];
   logic [CW-1:0] mem [NB];
   logic [CW-1:0] rd_q = '0;
   bit            seeded = 1'b0;
   logic          stall_prev = 1'b0;
   logic [BW+CW:0] held = '0;

   histogram_ctrl_if #(.BIN_W(BW), .COUNT_W(CW)) hb ();

   histogram_ctrl #(
      .NUM_BINS(NB),
      .BIN_W   (BW),
      .COUNT_W (CW),
      .RD_LAT  (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(hb)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Histogram memory: accumulate when rw=1, one-cycle read-and-zero when rw=0.
   // Seeded with non-zero junk so an incomplete clear shows up in the readout.
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < NB; i++) mem[i] <= CW'(i * 3 + 7);
         seeded <= 1'b1;
      end else if (hb.hist_rw) begin
         if (hb.hist_pixel_valid) mem[hb.hist_pixel] <= mem[hb.hist_pixel] + 1'b1;
      end else begin
         rd_q             <= mem[hb.hist_bin];
         mem[hb.hist_bin] <= '0;
      end
   end
   assign hb.hist_data = rd_q;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   always @(negedge clk) begin
      if (!rst) begin
         stall_prev = 1'b0;
      end else begin
         if (hb.frame_dropped) drop_seen++;
         if (stall_prev)
            check("stall_hold", {hb.out_valid, hb.out_bin, hb.out_count, hb.out_last}, {1'b1, held});
         if (hb.out_valid && hb.out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL beat_extra: got bin %0d, expected no beat", hb.out_bin);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat", {hb.out_bin, hb.out_count, hb.out_last}, mon_e);
            end
         end
         stall_prev = hb.out_valid && !hb.out_ready;
         held       = {hb.out_bin, hb.out_count, hb.out_last};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [BW-1:0] p, input logic v, input logic fe, input logic fs);
      hb.pix_in       = p;
      hb.pix_in_valid = v;
      hb.frame_end    = fe;
      hb.frame_start  = fs;
      if (v) exp_hist[p] = exp_hist[p] + 1;
      tick();
      hb.pix_in_valid = 1'b0;
      hb.frame_end    = 1'b0;
      hb.frame_start  = 1'b0;
   endtask

   task automatic pulse_start();
      hb.frame_start = 1'b1;
      tick();
      hb.frame_start = 1'b0;
   endtask

   task automatic push_frame();
      beat_t e;
      for (int b = 0; b < NB; b++) begin
         e.bin  = BW'(b);
         e.cnt  = CW'(exp_hist[b]);
         e.last = (b == NB - 1);
         exp_q.push_back(e);
         exp_hist[b] = 0;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (hb.busy && n < budget) begin
         tick();
         n++;
      end
      check(name, hb.busy, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: still running at cycle %0d, expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int good;
      int n;
      int drops0;

      hb.frame_start  = 1'b0;
      hb.frame_end    = 1'b0;
      hb.pix_in       = '0;
      hb.pix_in_valid = 1'b0;
      hb.out_ready    = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_busy",        hb.busy,             1'b1);
      check("rst_out_valid",   hb.out_valid,        1'b0);
      check("rst_hist_rw",     hb.hist_rw,          1'b0);
      check("rst_hist_bin",    hb.hist_bin,         '0);
      check("rst_image_done",  hb.hist_image_done,  1'b0);
      check("rst_pix_valid",   hb.hist_pixel_valid, 1'b0);
      check("rst_pixel_count", hb.pixel_count,      '0);
      check("rst_frame_count", hb.frame_count,      '0);

      // Clear sweep after release
      rst  = 1'b1;
      good = 0;
      for (int k = 0; k < NB; k++) begin
         if (hb.hist_bin == BW'(k) && !hb.hist_rw && !hb.out_valid && hb.busy) good++;
         tick();
      end
      check("clear_sweep",   good,    NB);
      check("clear_to_idle", hb.busy, 1'b0);

      // Pixels and frame_end outside ACQ are ignored
      hb.pix_in       = 10'd3;
      hb.pix_in_valid = 1'b1;
      hb.frame_end    = 1'b1;
      tick();
      hb.pix_in_valid = 1'b0;
      hb.frame_end    = 1'b0;
      check("idle_pix_ignored", hb.hist_pixel_valid, 1'b0);
      check("idle_fe_ignored",  hb.busy,             1'b0);

      // Single frame with latency checks
      beats        = 0;
      hb.out_ready = 1'b1;
      pulse_start();
      check("acq_busy", hb.busy, 1'b1);
      pix(10'd5, 1'b1, 1'b0, 1'b0);
      check("pix_latency", {hb.hist_pixel_valid, hb.hist_pixel}, {1'b1, 10'd5});
      pix(10'd5, 1'b1, 1'b0, 1'b0);
      pix(10'd77, 1'b0, 1'b0, 1'b0);
      check("pix_invalid", hb.hist_pixel_valid, 1'b0);
      pix(10'd5, 1'b1, 1'b0, 1'b0);
      pix(10'd1023, 1'b1, 1'b0, 1'b0);
      pix(10'd300, 1'b0, 1'b0, 1'b0);
      pix(10'd0, 1'b1, 1'b1, 1'b0);
      push_frame();
      check("lat_t1_done", hb.hist_image_done, 1'b0);
      check("lat_t1_pix",  {hb.hist_pixel_valid, hb.hist_pixel}, {1'b1, 10'd0});
      tick();
      check("lat_t2", {hb.hist_image_done, hb.hist_rw}, 2'b11);
      tick();
      check("lat_t3", {hb.hist_image_done, hb.hist_rw, hb.hist_bin, hb.out_valid}, {1'b0, 1'b0, 10'd0, 1'b0});
      tick();
      check("lat_t4_valid", hb.out_valid, 1'b0);
      tick();
      check("lat_t5_valid", hb.out_valid, 1'b1);
      wait_idle("sf_done", 5000);
      check("sf_pixel_count", hb.pixel_count, 32'd5);
      check("sf_frame_count", hb.frame_count, 16'd1);
      check("sf_queue_empty", exp_q.size(), 0);
      check("sf_beats",       beats, NB);

      // Backpressure frame with two rejected frame_starts
      beats  = 0;
      drops0 = drop_seen;
      pulse_start();
      pix(10'd7, 1'b1, 1'b0, 1'b0);
      pix(10'd7, 1'b1, 1'b0, 1'b0);
      pix(10'd512, 1'b1, 1'b0, 1'b0);
      pix(10'd1023, 1'b1, 1'b1, 1'b1);
      push_frame();
      for (int i = 0; i < 20000 && hb.busy; i++) begin
         hb.out_ready   = 1'($urandom_range(0, 1));
         hb.frame_start = (i == 50);
         tick();
      end
      hb.frame_start = 1'b0;
      hb.out_ready   = 1'b1;
      check("bp_done", hb.busy, 1'b0);
      tick();
      tick();
      check("bp_drops",       drop_seen - drops0, 2);
      check("bp_pixel_count", hb.pixel_count, 32'd4);
      check("bp_frame_count", hb.frame_count, 16'd2);
      check("bp_queue_empty", exp_q.size(), 0);
      check("bp_beats",       beats, NB);

      // Reset during readout while bin 400 is stalled
      beats = 0;
      pulse_start();
      pix(10'd400, 1'b1, 1'b0, 1'b0);
      pix(10'd401, 1'b1, 1'b0, 1'b0);
      pix(10'd9, 1'b1, 1'b1, 1'b0);
      push_frame();
      n = 0;
      while (!(hb.hist_bin == 10'd400 && !hb.hist_rw) && n < 3000) begin
         tick();
         n++;
      end
      hb.out_ready = 1'b0;
      n = 0;
      while (!hb.out_valid && n < 10) begin
         tick();
         n++;
      end
      check("mr_stall_bin", {hb.out_valid, hb.out_bin}, {1'b1, 10'd400});
      check("mr_beats", beats, 400);
      #2 rst = 1'b0;
      #1;
      check("mr_abort_valid", hb.out_valid,   1'b0);
      check("mr_frame_count", hb.frame_count, 16'd0);
      check("mr_busy",        hb.busy,        1'b1);
      exp_q.delete();
      tick();
      tick();
      rst = 1'b1;
      wait_idle("mr_clear", 1100);

      // Empty frame after the re-clear reads back all zeros
      beats        = 0;
      hb.out_ready = 1'b1;
      pulse_start();
      pix(10'd11, 1'b0, 1'b0, 1'b0);
      pix(10'd12, 1'b0, 1'b1, 1'b0);
      push_frame();
      wait_idle("ef_done", 5000);
      check("ef_queue_empty", exp_q.size(), 0);
      check("ef_beats",       beats, NB);
      check("ef_frame_count", hb.frame_count, 16'd1);
      check("ef_pixel_count", hb.pixel_count, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
